uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- Serial UART transmitter: 8N1 framing, LSB first, idle-high line.
- Partner to the UART byte receiver on the rs232 link; uses the same baud_set encoding so both ends are configured from one register.
- Has a one-entry holding register, so a producer can queue the next byte while the current frame is shifting out.
- Sits between the SDRAM/VGA readback path and the board's TX pin.

Parameters:
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- baud_set  in  4  baud select, sampled at frame start.
- send_en  in  1  request: data_byte is valid this cycle.
- data_byte  in  8  byte to transmit.
- send_ready  out  1  holding register empty; a send_en is accepted only while this is 1.
- rs232_tx  out  1  serial line, registered.
- uart_state  out  1  1 while a frame is on the line.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - Reset values: rs232_tx=1, uart_state=0, tx_done=0, send_ready=1. Holding register is emptied, FSM goes to IDLE, counters clear.
- Bit period DIV, in clocks, from baud_set:
  - 0 -> 5208 (9600)
  - 1 -> 2604 (19200)
  - 2 -> 1302 (38400)
  - 3 -> 868 (57600)
  - 4 -> 434 (115200)
  - 5 -> 16 (simulation/test)
  - other -> 5208
- DIV handling:
  - DIV is latched into a 13-bit register when a frame starts. baud_set changes mid-frame take effect on the next frame only.
  - Divider counts 0..DIV-1. Every bit is held exactly DIV clocks.
- Accept rule:
  - On an edge where send_en=1 and send_ready=1, data_byte is written to the holding register; send_ready goes 0 after that edge.
  - send_en while send_ready=0 is ignored: the byte is dropped and no state changes.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: rs232_tx=1, uart_state=0. If the holding register is valid, on the next edge: load the shift register, latch DIV, empty the holding register (send_ready=1), go to START.
  - START: rs232_tx=0 for DIV clocks, then DATA.
  - DATA: bit_cnt 0..7, shift register LSB driven each bit. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: rs232_tx=1 for DIV clocks. tx_done=1 during the final clock of STOP. Then:
    - holding register valid -> load it and go to START directly (no idle gap; uart_state stays 1);
    - otherwise -> IDLE.
- Latency:
  - send_en accepted at edge E0 while IDLE -> holding register valid after E0 -> load at E1 -> rs232_tx=0 from E1.
  - Frame length is 10*DIV clocks (11*DIV with parity).
- Simultaneous events:
  - Holding register drained at the same edge as a send_en: send_ready was 0 that cycle, so no accept. A new accept is possible the next cycle.
  - tx_done and a frame restart on the same edge are legal.
- Reset mid-frame: line returns to 1 on the reset edge, the frame is truncated, the holding register is discarded, and no tx_done is generated.
- rs232_tx is driven from a flop; no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting DIV clocks.
  - Parity bit = XOR of the 8 data bits, XOR PARITY_ODD.
  - Frame length is 11*DIV.
- Undefined: no PARITY state, 8N1 only, frame length 10*DIV.

Test Plan:
- baud_set=5, send 0xA5 from IDLE:
  - rs232_tx=0 from E1 for 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), then stop 1 for 16.
  - tx_done is high exactly at the 160th clock after E1; uart_state falls the following cycle.
- baud_set=5, queue back-to-back:
  - Send 0x55, then 0x0F as soon as send_ready returns to 1.
  - Expect: second start bit immediately after the first stop bit, uart_state high continuously for 320 clocks, two tx_done pulses 160 clocks apart.
- Overrun:
  - Issue a third send_en while send_ready=0 -> that byte never appears on the line; the first two frames are unchanged.
- baud_set=4, send 0x00:
  - Every bit (start, 8 data) is low for exactly 434 clocks; stop is high for 434; frame is 4340 clocks.
- baud_set switches 5->0 during a frame:
  - Current frame keeps 16-clock bits; the next queued frame uses 5208-clock bits.
- Reset:
  - Assert rst during data bit 3 of 0xFF -> rs232_tx=1, uart_state=0, send_ready=1 after the reset edge, no tx_done.
  - With UART_TX_PARITY_EN and PARITY_ODD=0, 0x07 -> parity bit=1 and frame is 176 clocks at baud_set=5.

Source files
------------

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serial UART transmitter, 8N1, LSB first, idle-high line.
// A one-entry holding register lets a producer queue the next byte while the
// current frame shifts out, so back-to-back frames leave no idle gap.
// Optional even/odd parity bit between the data bits and the stop bit is
// enabled by defining the macro UART_TX_PARITY_EN (sense chosen by PARITY_ODD).
module uart_byte_tx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud_set,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  output logic       send_ready,
  output logic       rs232_tx,
  output logic       uart_state,
  output logic       tx_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  r_state;
  logic        r_tx;
  logic [12:0] r_div;
  logic [12:0] r_div_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_hold_valid;
  logic [7:0]  r_hold_data;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`else
  logic        w_unused_parity;
  assign w_unused_parity = PARITY_ODD;
`endif

  logic [12:0] w_div;
  logic        w_bit_end;
  logic        w_frame_end;
  logic        w_load;

  // Bit period in clocks for the requested baud rate (same table as the receiver).
  always_comb begin
    w_div = 13'd5208;
    case (baud_set)
      4'd0:    w_div = 13'd5208;
      4'd1:    w_div = 13'd2604;
      4'd2:    w_div = 13'd1302;
      4'd3:    w_div = 13'd868;
      4'd4:    w_div = 13'd434;
      4'd5:    w_div = 13'd16;
      default: w_div = 13'd5208;
    endcase
  end

  assign w_bit_end   = (r_div_cnt == (r_div - 13'd1));
  assign w_frame_end = (r_state == S_STOP) && w_bit_end;
  // A new frame starts from IDLE or straight out of the last stop-bit clock.
  assign w_load      = r_hold_valid && ((r_state == S_IDLE) || w_frame_end);

  assign send_ready = ~r_hold_valid;
  assign rs232_tx   = r_tx;
  assign uart_state = (r_state != S_IDLE);
  assign tx_done    = w_frame_end;

  // Holding register: filled by an accepted send_en, emptied when a frame loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= 8'd0;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end else if (send_en && !r_hold_valid) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= data_byte;
    end
  end

  // Frame sequencer: drives the registered line level for the next clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_div     <= 13'd5208;
      r_div_cnt <= 13'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (w_load) begin
      r_state   <= S_START;
      r_tx      <= 1'b0;
      r_div     <= w_div;
      r_div_cnt <= 13'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= r_hold_data;
`ifdef UART_TX_PARITY_EN
      r_parity  <= (^r_hold_data) ^ PARITY_ODD;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_div_cnt <= 13'd0;
        end
        S_START: begin
          if (w_bit_end) begin
            r_div_cnt <= 13'd0;
            r_bit_cnt <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_div_cnt <= r_div_cnt + 13'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_div_cnt <= 13'd0;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_div_cnt <= r_div_cnt + 13'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_div_cnt <= 13'd0;
            r_tx      <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_div_cnt <= r_div_cnt + 13'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_div_cnt <= 13'd0;
            r_tx      <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 13'd1;
          end
        end
        default: begin
          r_tx      <= 1'b1;
          r_div_cnt <= 13'd0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx with a cycle-timeline model
// of the serial line plus hand-computed checks on bit levels and frame timing.
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] baud_set = 4'd5;
  logic       send_en = 1'b0;
  logic [7:0] data_byte = 8'd0;
  logic       send_ready;
  logic       rs232_tx;
  logic       uart_state;
  logic       tx_done;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int doneQ[$];
  int stateHighCnt = 0;
  bit checking = 1'b0;

  bit         qLine[$];
  bit         mHoldValid = 1'b0;
  logic [7:0] mHold = 8'd0;
  bit         mOldValid;

  uart_byte_tx #(.PARITY_ODD(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_set  (baud_set),
    .send_en   (send_en),
    .data_byte (data_byte),
    .send_ready(send_ready),
    .rs232_tx  (rs232_tx),
    .uart_state(uart_state),
    .tx_done   (tx_done)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Free-running cycle index, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int divOf(input logic [3:0] b);
    case (b)
      4'd0: return 5208;
      4'd1: return 2604;
      4'd2: return 1302;
      4'd3: return 868;
      4'd4: return 434;
      4'd5: return 16;
      default: return 5208;
    endcase
  endfunction

  // Expand a byte into the per-clock line levels of one whole frame.
  task automatic pushFrame(input logic [7:0] d, input int div);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < div; k++) qLine.push_back(bits[i]);
    end
  endtask

  // Model: the queue holds the line level for every remaining clock of the frame.
  always @(posedge clk) begin
    if (rst) begin
      qLine.delete();
      mHoldValid = 1'b0;
    end else begin
      mOldValid = mHoldValid;
      if (qLine.size() > 0) void'(qLine.pop_front());
      if (qLine.size() == 0 && mOldValid) begin
        pushFrame(mHold, divOf(baud_set));
        mHoldValid = 1'b0;
      end else if (send_en && !mOldValid) begin
        mHoldValid = 1'b1;
        mHold = data_byte;
      end
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%b required=%b cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rs232_tx", rs232_tx, (qLine.size() > 0) ? qLine[0] : 1'b1);
      checkOutput("uart_state", uart_state, qLine.size() > 0);
      checkOutput("tx_done", tx_done, qLine.size() == 1);
      checkOutput("send_ready", send_ready, !mHoldValid);
      if (tx_done) doneQ.push_back(cyc);
      if (uart_state) stateHighCnt++;
    end
  end

  // Offer a byte for exactly one edge; called and returns at a falling edge.
  task automatic applyStimulus(input logic [7:0] d);
    send_en = 1'b1;
    data_byte = d;
    @(negedge clk);
    send_en = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #3ms;
    $display("[TB] FAIL timeout cycle=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    int t0;
    int n;
    int lowCnt;
    logic [8:0] patA5 = 9'b101001010;
    logic [8:0] pat55 = 9'b010101010;
    logic [8:0] pat0F = 9'b000011110;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset rs232_tx", rs232_tx, 1'b1);
    checkOutput("reset uart_state", uart_state, 1'b0);
    checkOutput("reset send_ready", send_ready, 1'b1);
    checkOutput("reset tx_done", tx_done, 1'b0);

    // Single 0xA5 frame at 16 clocks per bit.
    baud_set = 4'd5;
    doneQ.delete();
    applyStimulus(8'hA5);
    t0 = cyc;
    @(negedge clk);
    checkInt("model frame length", qLine.size(), NBITS * 16);
    for (int k = 0; k < 9; k++) begin
      waitUntil(t0 + 1 + 16 * k + 8);
      checkOutput($sformatf("A5 bit%0d", k), rs232_tx, patA5[k]);
    end
    waitUntil(t0 + 1 + 16 * (NBITS - 1) + 8);
    checkOutput("A5 stop", rs232_tx, 1'b1);
    waitUntil(t0 + NBITS * 16);
    checkOutput("A5 last clock tx_done", tx_done, 1'b1);
    checkOutput("A5 last clock uart_state", uart_state, 1'b1);
    waitUntil(t0 + NBITS * 16 + 1);
    checkOutput("A5 uart_state after", uart_state, 1'b0);
    waitUntil(t0 + NBITS * 16 + 2);
    checkInt("A5 tx_done count", doneQ.size(), 1);
    if (doneQ.size() > 0) checkInt("A5 tx_done offset", doneQ[0] - t0, NBITS * 16);

    // Back-to-back 0x55 then 0x0F, plus an overrun byte that must be dropped.
    doneQ.delete();
    stateHighCnt = 0;
    applyStimulus(8'h55);
    t0 = cyc;
    n = 0;
    while (!send_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkInt("send_ready return delay", n, 1);
    applyStimulus(8'h0F);
    checkOutput("send_ready while held", send_ready, 1'b0);
    applyStimulus(8'hC3);
    for (int k = 0; k < 9; k++) begin
      waitUntil(t0 + 1 + 16 * k + 8);
      checkOutput($sformatf("55 bit%0d", k), rs232_tx, pat55[k]);
    end
    for (int k = 0; k < 9; k++) begin
      waitUntil(t0 + 1 + NBITS * 16 + 16 * k + 8);
      checkOutput($sformatf("0F bit%0d", k), rs232_tx, pat0F[k]);
    end
    waitUntil(t0 + 2 * NBITS * 16 + 3);
    checkInt("b2b tx_done count", doneQ.size(), 2);
    if (doneQ.size() == 2) begin
      checkInt("b2b first tx_done", doneQ[0] - t0, NBITS * 16);
      checkInt("b2b tx_done gap", doneQ[1] - doneQ[0], NBITS * 16);
    end
    checkInt("b2b uart_state high clocks", stateHighCnt, 2 * NBITS * 16);
    checkOutput("overrun byte not sent", uart_state, 1'b0);

    // All-zero byte at 434 clocks per bit.
    doneQ.delete();
    baud_set = 4'd4;
    applyStimulus(8'h00);
    t0 = cyc;
    waitUntil(t0 + 1);
    lowCnt = 0;
    while (rs232_tx == 1'b0 && lowCnt < 6000) begin
      lowCnt++;
      @(negedge clk);
    end
    checkInt("0x00 low run", lowCnt, (NBITS - 1) * 434);
    waitUntil(t0 + NBITS * 434 + 2);
    checkInt("0x00 tx_done count", doneQ.size(), 1);
    if (doneQ.size() > 0) checkInt("0x00 frame length", doneQ[0] - t0, NBITS * 434);

    // Baud change mid-frame: current frame keeps 16, queued frame uses 5208.
    doneQ.delete();
    baud_set = 4'd5;
    applyStimulus(8'h3C);
    t0 = cyc;
    @(negedge clk);
    applyStimulus(8'h81);
    waitUntil(t0 + 50);
    baud_set = 4'd0;
    waitUntil(t0 + NBITS * 16 + 2);
    checkInt("switch first frame tx_done", doneQ.size(), 1);
    if (doneQ.size() > 0) checkInt("switch first frame length", doneQ[0] - t0, NBITS * 16);
    waitUntil(t0 + NBITS * 16 + 1 + 5207);
    checkOutput("switch start bit end", rs232_tx, 1'b0);
    waitUntil(t0 + NBITS * 16 + 1 + 5208);
    checkOutput("switch data bit0", rs232_tx, 1'b1);
    waitUntil(t0 + NBITS * 16 + 1 + 6000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-frame reset line", rs232_tx, 1'b1);
    checkOutput("mid-frame reset uart_state", uart_state, 1'b0);

    // Reset during data bit 3 of 0xFF with a byte waiting in the holding register.
    doneQ.delete();
    baud_set = 4'd5;
    applyStimulus(8'hFF);
    t0 = cyc;
    @(negedge clk);
    applyStimulus(8'h12);
    waitUntil(t0 + 70);
    checkOutput("FF bit3 level", rs232_tx, 1'b1);
    checkOutput("FF held byte", send_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("FF reset line", rs232_tx, 1'b1);
    checkOutput("FF reset uart_state", uart_state, 1'b0);
    checkOutput("FF reset send_ready", send_ready, 1'b1);
    checkOutput("FF reset tx_done", tx_done, 1'b0);
    waitUntil(t0 + 300);
    checkInt("FF no tx_done", doneQ.size(), 0);
    checkOutput("FF stays idle", uart_state, 1'b0);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; frame is 11 bits long.
    doneQ.delete();
    applyStimulus(8'h07);
    t0 = cyc;
    waitUntil(t0 + 1 + 16 * 9 + 8);
    checkOutput("0x07 parity bit", rs232_tx, 1'b1);
    waitUntil(t0 + 178);
    checkInt("0x07 tx_done count", doneQ.size(), 1);
    if (doneQ.size() > 0) checkInt("0x07 frame length", doneQ[0] - t0, 176);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
